// File: rtl/mem_responder_pkg.sv
// Shared types and defaults for the memory responder slice.
package mem_responder_pkg;

    localparam int unsigned DATA_W_DEF      = 32;
    localparam int unsigned ADDR_W_DEF      = 32;
    localparam int unsigned DEPTH_DEF       = 512;
    localparam int unsigned WAIT_STATES_DEF = 2;
    localparam int unsigned CNT_W           = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_HOLD   = 2'd3
    } state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

endpackage

// File: rtl/mem_responder_if.sv
// Read/Write strobe bus between the datapath (MAR/MDR) and the memory responder.
interface mem_responder_if
    import mem_responder_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) ();

    logic              Read;
    logic              Write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] Mdatain;
    logic              mem_done;
    logic              busy;
    logic              err;

    modport master (
        output Read, Write, addr, wdata,
        input  Mdatain, mem_done, busy, err
    );

    modport slave (
        input  Read, Write, addr, wdata,
        output Mdatain, mem_done, busy, err
    );

endinterface

// File: rtl/mem_responder_mem_array.sv
// Single-port synchronous word RAM: write-enable, registered read with read-enable.
// Contents are not preloaded and are never cleared by reset.
module mem_array #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 512,
    parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              re,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Storage write and registered read port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[idx] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[idx];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one strobe request, waits WAIT_STATES cycles,
// performs the RAM access and pulses mem_done; four-phase return via HOLD.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned DEPTH       = DEPTH_DEF,
    parameter int unsigned WAIT_STATES = WAIT_STATES_DEF
) (
    input  logic           Clock,
    input  logic           clear_n,
    mem_responder_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] mdatain_q, mdatain_d;
    logic              mem_done_q, mem_done_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;

    logic              oor_c;
    logic              ram_re_c;
    logic              ram_we_c;
    logic [DATA_W-1:0] ram_rdata;

    // Latched address lies beyond the implemented words
    assign oor_c = (addr_q >= ADDR_W'(DEPTH));

    // Next-state, request latching and output computation
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        mdatain_d  = mdatain_q;
        mem_done_d = 1'b0;
        err_d      = 1'b0;
        ram_we_c   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.Read && bus.Write) begin
                    mem_done_d = 1'b1;
                    err_d      = 1'b1;
                    state_d    = S_HOLD;
                end else if (bus.Read || bus.Write) begin
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    op_d    = bus.Write ? OP_WRITE : OP_READ;
                    cnt_d   = CNT_W'(WAIT_STATES);
                    state_d = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                mem_done_d = 1'b1;
                err_d      = oor_c;
                if (op_q == OP_READ) begin
                    mdatain_d = oor_c ? '0 : ram_rdata;
                end else begin
                    ram_we_c = ~oor_c;
                end
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (!bus.Read && !bus.Write) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // RAM read is launched on the edge entering ACCESS so data is ready during ACCESS
        ram_re_c = (state_d == S_ACCESS) && (op_d == OP_READ);
        busy_d   = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge Clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q    <= S_IDLE;
            op_q       <= OP_READ;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            mdatain_q  <= '0;
            mem_done_q <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            mdatain_q  <= mdatain_d;
            mem_done_q <= mem_done_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_mem_array (
        .clk   (Clock),
        .re    (ram_re_c),
        .we    (ram_we_c),
        .idx   (addr_d[IDX_W-1:0]),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    assign bus.Mdatain  = mdatain_q;
    assign bus.mem_done = mem_done_q;
    assign bus.err      = err_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed table, reset corner case,
// then randomized traffic checked against an associative-array memory model.
module tb_mem_responder;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 512;
    localparam int unsigned WS    = 2;
    // mem_done is seen on the (WS+2)th falling edge after the request is driven
    localparam int          LAT   = WS + 2;

    logic clk = 1'b0;
    logic clear_n;
    always #5 clk = ~clk;

    mem_responder_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    mem_responder #(
        .DATA_W      (DW),
        .ADDR_W      (AW),
        .DEPTH       (DEPTH),
        .WAIT_STATES (WS)
    ) dut (
        .Clock   (clk),
        .clear_n (clear_n),
        .bus     (bus)
    );

    int checks = 0;
    int passes = 0;

    logic [31:0] model_mem [int unsigned];
    logic [31:0] model_md;
    bit          md_known;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] a;
        logic [31:0] d;
        int          hold;
        bit          exp_err;
        logic [31:0] exp_md;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    endtask

    // One four-phase transaction with expected latency / err / read data
    task automatic txn(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input int hold, input bit exp_err, input logic [31:0] exp_md,
                       input bit md_chk, input int exp_lat, input string tag);
        int lat = -1;
        int bad = 0;
        bus.Read  = rd;
        bus.Write = wr;
        bus.addr  = a;
        bus.wdata = d;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.addr  = $urandom;
                bus.wdata = $urandom;
            end
            if (bus.busy !== 1'b1) bad++;
            if (bus.mem_done === 1'b1) begin
                lat = k;
                break;
            end
        end
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, " err"}, 64'(bus.err), 64'(exp_err));
        if (md_chk) chk({tag, " Mdatain"}, 64'(bus.Mdatain), 64'(exp_md));
        repeat (hold) begin
            @(negedge clk);
            if (bus.mem_done !== 1'b0 || bus.busy !== 1'b1 || bus.err !== 1'b0) bad++;
        end
        chk({tag, " busy/hold"}, 64'(bad), 64'(0));
        bus.Read  = 1'b0;
        bus.Write = 1'b0;
        @(negedge clk);
        chk({tag, " release"}, 64'({bus.busy, bus.mem_done, bus.err}), 64'(0));
        if (md_chk) chk({tag, " Mdatain held"}, 64'(bus.Mdatain), 64'(exp_md));
    endtask

    // Transaction whose expectations come from the memory model
    task automatic model_txn(input bit rd, input bit wr, input logic [31:0] a,
                             input logic [31:0] d, input int hold);
        bit oor = (a >= DEPTH);
        bit e;
        int lat;
        if (rd && wr) begin
            e   = 1'b1;
            lat = 1;
        end else begin
            e   = oor;
            lat = LAT;
            if (wr) begin
                if (!oor) model_mem[a] = d;
            end else if (oor) begin
                model_md = '0;
                md_known = 1'b1;
            end else if (model_mem.exists(a)) begin
                model_md = model_mem[a];
                md_known = 1'b1;
            end else begin
                md_known = 1'b0;
            end
        end
        txn(rd, wr, a, d, hold, e, model_md, md_known, lat, "rand");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        clear_n   = 1'b0;
        bus.Read  = 1'b0;
        bus.Write = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        #12;
        chk("reset Mdatain", 64'(bus.Mdatain), 64'(0));
        chk("reset mem_done", 64'(bus.mem_done), 64'(0));
        chk("reset busy", 64'(bus.busy), 64'(0));
        chk("reset err", 64'(bus.err), 64'(0));
        @(negedge clk);
        clear_n = 1'b1;
        @(negedge clk);

        //                rd wr addr           data          hold err Mdatain        lat
        vecs.push_back('{1'b0, 1'b1, 32'd5,   32'hDEADBEEF, 0,  1'b0, 32'h0,        LAT});
        vecs.push_back('{1'b1, 1'b0, 32'd5,   32'h0,        2,  1'b0, 32'hDEADBEEF, LAT});
        vecs.push_back('{1'b1, 1'b1, 32'd5,   32'h12345678, 0,  1'b1, 32'hDEADBEEF, 1});
        vecs.push_back('{1'b0, 1'b1, 32'd88,  32'h00000088, 0,  1'b0, 32'hDEADBEEF, LAT});
        vecs.push_back('{1'b0, 1'b1, 32'd600, 32'hBAD0BAD0, 0,  1'b1, 32'hDEADBEEF, LAT});
        vecs.push_back('{1'b1, 1'b0, 32'd88,  32'h0,        0,  1'b0, 32'h00000088, LAT});
        vecs.push_back('{1'b1, 1'b0, 32'd5,   32'h0,        10, 1'b0, 32'hDEADBEEF, LAT});
        vecs.push_back('{1'b1, 1'b0, 32'd600, 32'h0,        1,  1'b1, 32'h0,        LAT});
        vecs.push_back('{1'b0, 1'b1, 32'd7,   32'h77777777, 0,  1'b0, 32'h0,        LAT});
        vecs.push_back('{1'b1, 1'b0, 32'd7,   32'h0,        0,  1'b0, 32'h77777777, LAT});
        vecs.push_back('{1'b1, 1'b1, 32'd7,   32'h0,        3,  1'b1, 32'h77777777, 1});

        foreach (vecs[i]) begin
            txn(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].hold,
                vecs[i].exp_err, vecs[i].exp_md, 1'b1, vecs[i].exp_lat, $sformatf("vec%0d", i));
        end

        // Reset asserted while a write to addr 7 is waiting: write dropped, outputs cleared
        bus.Write = 1'b1;
        bus.addr  = 32'd7;
        bus.wdata = 32'h0BAD0BAD;
        @(negedge clk);
        chk("wait busy", 64'(bus.busy), 64'(1));
        clear_n = 1'b0;
        #1;
        chk("midreset outputs", 64'({bus.Mdatain, bus.mem_done, bus.busy, bus.err}), 64'(0));
        bus.Write = 1'b0;
        @(negedge clk);
        @(negedge clk);
        clear_n = 1'b1;
        @(negedge clk);
        txn(1'b1, 1'b0, 32'd7, 32'h0, 0, 1'b0, 32'h77777777, 1'b1, LAT, "post-reset read7");

        model_md = 32'h77777777;
        md_known = 1'b1;
        model_mem[5]  = 32'hDEADBEEF;
        model_mem[7]  = 32'h77777777;
        for (int i = 0; i < 32; i++) model_txn(1'b0, 1'b1, 32'(i), $urandom, 0);
        for (int i = 0; i < 60; i++) begin
            int          sel = int'($urandom_range(0, 9));
            logic [31:0] a;
            if ($urandom_range(0, 4) == 0) a = 32'(DEPTH) + $urandom_range(0, 1000);
            else a = 32'($urandom_range(0, 31));
            model_txn(sel <= 5 && sel != 0 ? 1'b1 : (sel == 0), sel >= 6 || sel == 0 ? 1'b1 : 1'b0,
                      a, $urandom, int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
